pc_sequencer: RTL

- Next-PC controller for the 5-stage pipeline: each cycle, chooses among sequential fetch, the EX-stage branch, the ID-stage jr, and the ID-stage j/jal target.
- Builds the j/jal target, holds the PC during hazard stalls and keeps a redirect raised during a stall until the stall releases.
- Drives IF/ID flush signals and a redirect counter. Sits between the hazard unit, the ID/EX stages and the instruction-memory address.

---
 rtl/pc_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Next-PC controller for the 5-stage pipeline. Every cycle it picks the next
// fetch address from sequential fetch (pc+4), the EX-stage taken branch, the
// ID-stage jr/jalr register target, or the ID-stage j/jal target. It holds the
// PC while the hazard unit stalls. A redirect that arrives during a stall is
// parked in a pending register and applied on the first unstalled edge. It
// also drives the IF/ID and ID/EX flush strobes and a saturating count of
// applied redirects.
//
// Redirect priority: br_taken > jr_req > j_req > pc+4. The branch wins because
// it belongs to the older instruction, which is already in EX.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hazard-unit stall: hold pc and IF/ID
//   br_taken     in   EX-stage branch resolved taken
//   br_target    in   EX-stage branch target (low two bits ignored)
//   jr_req       in   ID-stage jr/jalr decoded
//   jr_target    in   register value for jr (low two bits ignored)
//   j_req        in   ID-stage j/jal decoded
//   j_index      in   instr[25:0] of the j/jal
//   id_pc_plus4  in   PC+4 of the instruction in ID
//   pc           out  current fetch address (registered)
//   fetch_valid  out  pc is a real fetch; low for the boot cycle after reset
//   flush_if     out  discard the IF/ID instruction this cycle (combinational)
//   flush_id     out  discard the ID/EX instruction this cycle (combinational)
//   redirect_cnt out  count of applied redirects, saturates at all-ones
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jr_req,
  input  logic [31:0]      jr_target,
  input  logic             j_req,
  input  logic [25:0]      j_index,
  input  logic [31:0]      id_pc_plus4,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,   // first cycle out of reset: pc not yet a real fetch
    RUN  = 2'd1,   // normal operation
    HOLD = 2'd2    // stalled with a redirect waiting to be applied
  } state_t;

  // Kind of redirect; it decides which pipeline registers get flushed.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,  // flushes IF/ID and ID/EX
    JR     = 2'd2,  // flushes IF/ID only
    JUMP   = 2'd3   // flushes IF/ID only
  } kind_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic        pend_valid;
  kind_t       pend_kind;
  logic [31:0] pend_target;

  // ---------------------------------------------------------------------------
  // Target formation
  // ---------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] br_aligned;
  logic [31:0] jr_aligned;
  logic [31:0] j_target;

  // 32-bit add; the carry out is dropped so 0xFFFF_FFFC wraps to 0.
  assign pc_plus4   = pc + 32'd4;
  assign br_aligned = {br_target[31:2], 2'b00};
  assign jr_aligned = {jr_target[31:2], 2'b00};
  // j/jal stays inside the 256 MB region of the delay-slot address.
  assign j_target   = {id_pc_plus4[31:28], j_index, 2'b00};

  // ---------------------------------------------------------------------------
  // Highest-priority live request this cycle. A simultaneous jr and j resolves
  // to jr through the ordering of the if/else chain.
  // ---------------------------------------------------------------------------
  kind_t       live_kind;
  logic [31:0] live_target;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    live_kind   = NONE;
    live_target = pc_plus4;
    if (br_taken) begin
      live_kind   = BRANCH;
      live_target = br_aligned;
    end else if (jr_req) begin
      live_kind   = JR;
      live_target = jr_aligned;
    end else if (j_req) begin
      live_kind   = JUMP;
      live_target = j_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect actually applied on the coming edge. Stays NONE in BOOT and
  // whenever stall is high, which keeps the flush strobes quiet there.
  // When leaving HOLD, a live branch beats the pending redirect: the branch
  // is older than whatever was parked from ID.
  // ---------------------------------------------------------------------------
  kind_t       apply_kind;
  logic [31:0] apply_target;

  always_comb begin
    apply_kind   = NONE;
    apply_target = pc_plus4;
    unique case (state)
      RUN: begin
        if (!stall) begin
          apply_kind   = live_kind;
          apply_target = live_target;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (br_taken) begin
            apply_kind   = BRANCH;
            apply_target = br_aligned;
          end else if (pend_valid) begin
            apply_kind   = pend_kind;
            apply_target = pend_target;
          end
        end
      end
      default: ;
    endcase
  end

  // Flushes are forced low while reset is asserted, independent of the clock.
  assign flush_if = rst_n && (apply_kind != NONE);
  assign flush_id = rst_n && (apply_kind == BRANCH);

  // ---------------------------------------------------------------------------
  // Sequencer state, pc, pending redirect and redirect counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      pend_valid   <= 1'b0;
      pend_kind    <= NONE;
      pend_target  <= 32'h0000_0000;
      redirect_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register samples the
      // pre-edge values, so the order of statements below does not matter.
      unique case (state)
        BOOT: begin
          // pc already holds RESET_PC; requests seen during boot are dropped.
          state       <= RUN;
          fetch_valid <= 1'b1;
        end

        RUN: begin
          if (!stall) begin
            pc <= apply_target;
          end else if (live_kind != NONE) begin
            // Park the winner; pc stays put until the stall releases.
            pend_valid  <= 1'b1;
            pend_kind   <= live_kind;
            pend_target <= live_target;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (stall) begin
            // The ID instruction is frozen, so only a new branch from EX can
            // change what is pending.
            if (br_taken) begin
              pend_kind   <= BRANCH;
              pend_target <= br_aligned;
            end
          end else begin
            pc          <= apply_target;
            pend_valid  <= 1'b0;
            pend_kind   <= NONE;
            pend_target <= 32'h0000_0000;
            state       <= RUN;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase

      if ((apply_kind != NONE) && (redirect_cnt != CNT_MAX)) begin
        redirect_cnt <= redirect_cnt + CNT_ONE;
      end
    end
  end

endmodule
